// File: rtl/sdram_frame_writer_pkg.sv
// Shared definitions for the frame writer and the VGA read path.
// Holds the default geometry, the colour-bar width, the pattern mode
// encodings, the frame-writer FSM state encodings and a small helper
// that maps a colour-bar index to its pixel word.
package sdram_frame_writer_pkg;

    localparam int DEF_H_PIXELS = 640;
    localparam int DEF_V_LINES  = 480;
    localparam int BAR_WIDTH    = 80;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_SOLID   = 2'd0;
    localparam mode_t MODE_BARS    = 2'd1;
    localparam mode_t MODE_RAMP    = 2'd2;
    localparam mode_t MODE_CHECKER = 2'd3;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WRITE    = 2'd1;
    localparam logic [1:0] ST_LINE_END = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    // Bar index bit 1 drives red, bit 0 drives blue.
    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        return {(idx[1] ? 8'hFF : 8'h00), (idx[0] ? 8'hFF : 8'h00)};
    endfunction

endpackage

// File: rtl/frame_pattern_gen.sv
// Combinational test-pattern generator.
// Ports:
//   i_mode  - pattern select (solid, colour bars, ramp, checker)
//   i_solid - colour used in solid mode
//   i_x     - pixel column (10 bits)
//   i_y     - pixel row (9 bits)
//   o_word  - pixel word, [15:8] red, [7:0] blue
module frame_pattern_gen
    import sdram_frame_writer_pkg::*;
(
    input  logic [1:0]  i_mode,
    input  logic [15:0] i_solid,
    input  logic [9:0]  i_x,
    input  logic [8:0]  i_y,
    output logic [15:0] o_word
);

    logic [2:0] w_bar_idx;
    logic       w_unused_y0;

    // Only the low 3 bits of the bar number are meaningful; wider
    // frames simply wrap the bar sequence.
    assign w_bar_idx   = 3'(i_x / 10'(BAR_WIDTH));
    assign w_unused_y0 = i_y[0];

    always_comb begin
        o_word = 16'h0000;
        case (i_mode)
            MODE_SOLID:   o_word = i_solid;
            MODE_BARS:    o_word = bar_colour(w_bar_idx);
            MODE_RAMP:    o_word = {i_x[9:2], i_y[8:1]};
            MODE_CHECKER: o_word = (i_x[5] ^ i_y[5]) ? 16'hFFFF : 16'h0000;
            default:      o_word = 16'h0000;
        endcase
    end

endmodule

// File: rtl/sdram_frame_writer.sv
// Writes one full test-pattern frame into the SDRAM write FIFO per
// iSTART pulse, row-major with x fastest, honouring FIFO back-pressure.
// Ports:
//   iCLK, iRST      - write-side clock, synchronous active-high reset
//   iSTART          - pulse requesting a frame (ignored while busy)
//   iMODE, iSOLID   - pattern select and solid colour, latched at start
//   iFIFO_FULL      - write FIFO full; stalls the scan
//   oWR_DATA/oWR_EN - pixel word and write strobe
//   oBUSY, oDONE    - frame in progress, end-of-frame pulse
//   oFRAME_CNT      - completed frames (wraps)
//
// state    | meaning
// IDLE     | waiting for iSTART
// WRITE    | streaming pixels of the current line
// LINE_END | one-cycle gap between lines, advances y
// DONE     | one-cycle end-of-frame pulse, bumps the frame count
module sdram_frame_writer
    import sdram_frame_writer_pkg::*;
#(
    parameter int H_PIXELS = DEF_H_PIXELS,
    parameter int V_LINES  = DEF_V_LINES
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic [1:0]  iMODE,
    input  logic [15:0] iSOLID,
    input  logic        iFIFO_FULL,
    output logic [15:0] oWR_DATA,
    output logic        oWR_EN,
    output logic        oBUSY,
    output logic        oDONE,
    output logic [15:0] oFRAME_CNT
);

    localparam logic [9:0] X_LAST = 10'(H_PIXELS - 1);
    localparam logic [8:0] Y_LAST = 9'(V_LINES - 1);

    logic [1:0]  r_state;
    logic [9:0]  r_x;
    logic [8:0]  r_y;
    logic [1:0]  r_mode;
    logic [15:0] r_solid;
    logic        r_busy;
    logic [15:0] r_frame_cnt;
    logic        w_wr_en;

    // A full FIFO simply withholds the strobe; x/y only move on a
    // strobed cycle, so nothing is lost or repeated across a stall.
    assign w_wr_en = (r_state == ST_WRITE) && !iFIFO_FULL;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state     <= ST_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_mode      <= '0;
            r_solid     <= '0;
            r_busy      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (iSTART) begin
                        r_state <= ST_WRITE;
                        r_mode  <= iMODE;
                        r_solid <= iSOLID;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (w_wr_en) begin
                        if (r_x == X_LAST) begin
                            r_x     <= '0;
                            r_state <= ST_LINE_END;
                        end else begin
                            r_x <= r_x + 10'd1;
                        end
                    end
                end
                ST_LINE_END: begin
                    if (r_y == Y_LAST) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_y     <= r_y + 9'd1;
                        r_state <= ST_WRITE;
                    end
                end
                ST_DONE: begin
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    frame_pattern_gen u_pattern (
        .i_mode  (r_mode),
        .i_solid (r_solid),
        .i_x     (r_x),
        .i_y     (r_y),
        .o_word  (oWR_DATA)
    );

    assign oWR_EN     = w_wr_en;
    assign oBUSY      = r_busy;
    assign oDONE      = (r_state == ST_DONE);
    assign oFRAME_CNT = r_frame_cnt;

endmodule

// File: tb/tb_sdram_frame_writer.sv
`timescale 1ns/1ps
module tb_sdram_frame_writer;

    // Reduced geometry keeps each frame short while still covering the
    // first four colour bars, ramp bit positions and checker row 32.
    localparam int H      = 256;
    localparam int V      = 34;
    localparam int FRAME  = H * V;
    localparam int BUDGET = FRAME + V + 200;
    localparam int NPROBE = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] solid;
    logic        full;
    logic [15:0] wdata;
    logic        wr_en;
    logic        busy;
    logic        done;
    logic [15:0] fcnt;

    always #5 clk = ~clk;

    sdram_frame_writer #(.H_PIXELS(H), .V_LINES(V)) dut (
        .iCLK       (clk),
        .iRST       (rst),
        .iSTART     (start),
        .iMODE      (mode),
        .iSOLID     (solid),
        .iFIFO_FULL (full),
        .oWR_DATA   (wdata),
        .oWR_EN     (wr_en),
        .oBUSY      (busy),
        .oDONE      (done),
        .oFRAME_CNT (fcnt)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [1:0]  m_mode;
    logic [15:0] m_solid;

    // probe coordinates: 0:(0,0) 1:(79,0) 2:(80,0) 3:(160,0) 4:(240,0)
    // 5:(4,2) 6:(255,33) 7:(32,0) 8:(32,32)
    int px [NPROBE] = '{0, 79, 80, 160, 240, 4, 255, 32, 32};
    int py [NPROBE] = '{0, 0, 0, 0, 0, 2, 33, 0, 32};
    logic [15:0] cap [NPROBE];

    int   writes, gaps, dones, derr, full_wr, resume_idx;
    logic [15:0] resume_data;
    logic first_busy;
    bit   aborted;

    function automatic logic [15:0] pix(input logic [1:0] m, input logic [15:0] s,
                                        input int x, input int y);
        int idx;
        case (m)
            2'd0: return s;
            2'd1: begin
                idx = (x / 80) % 8;
                return {(((idx / 2) % 2) != 0) ? 8'hFF : 8'h00,
                        ((idx % 2) != 0) ? 8'hFF : 8'h00};
            end
            2'd2: return {8'((x / 4) % 256), 8'((y / 2) % 256)};
            default: return ((((x / 32) ^ (y / 32)) % 2) != 0) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [1:0] m, input logic [15:0] s);
        @(posedge clk); #1;
        start   = 1'b1;
        mode    = m;
        solid   = s;
        m_mode  = m;
        m_solid = s;
    endtask

    // Follows one frame cycle by cycle with the bench's own x/y model.
    task automatic run(input int stall_len, input int poke_y, input int abort_y);
        int  ex_x = 0;
        int  ex_y = 0;
        int  stall_left = 0;
        bit  stalled = 0;
        bit  resume_pend = 0;
        bit  poked = 0;
        writes = 0; gaps = 0; dones = 0; derr = 0; full_wr = 0;
        resume_idx = -1; resume_data = 'x; first_busy = 1'bx; aborted = 0;
        for (int k = 0; k < NPROBE; k++) cap[k] = 'x;
        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            full  = 1'b0;
            if (abort_y >= 0 && ex_y == abort_y) begin
                aborted = 1;
                return;
            end
            if (stall_len > 0 && !stalled && ex_x == 63 && ex_y == 0) begin
                stalled    = 1;
                stall_left = stall_len;
            end
            if (stall_left > 0) begin
                full = 1'b1;
                stall_left--;
                if (stall_left == 0) resume_pend = 1;
            end
            if (poke_y >= 0 && !poked && ex_y == poke_y && ex_x == 5) begin
                poked = 1;
                start = 1'b1;
                mode  = ~m_mode;
                solid = ~m_solid;
            end
            #1;
            if (cyc == 0) first_busy = busy;
            if (wr_en) begin
                if (full) full_wr++;
                if (resume_pend && !full) begin
                    resume_idx  = writes;
                    resume_data = wdata;
                    resume_pend = 0;
                end
                for (int k = 0; k < NPROBE; k++)
                    if (px[k] == ex_x && py[k] == ex_y) cap[k] = wdata;
                if (wdata !== pix(m_mode, m_solid, ex_x, ex_y)) derr++;
                writes++;
                ex_x++;
                if (ex_x == H) begin
                    ex_x = 0;
                    ex_y++;
                end
            end else if (busy && !done && !full) begin
                gaps++;
            end
            if (done) begin
                dones++;
                return;
            end
        end
    endtask

    task automatic after_done(input string tag, input logic [15:0] exp_cnt);
        @(posedge clk); #2;
        check({tag, "_busy_clr"}, 32'(busy), 32'd0);
        check({tag, "_done_1cyc"}, 32'(done), 32'd0);
        check({tag, "_frame_cnt"}, 32'(fcnt), 32'(exp_cnt));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 2'd0; solid = 16'h0; full = 1'b0;
        m_mode = 2'd0; m_solid = 16'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_cnt",   32'(fcnt),  32'd0);
        check("rst_data",  32'(wdata), 32'd0);

        // colour bars, no back-pressure
        do_start(2'd1, 16'h1234);
        run(0, -1, -1);
        check("bars_first_busy", 32'(first_busy), 32'd1);
        check("bars_writes", 32'(writes), 32'(FRAME));
        check("bars_gaps",   32'(gaps),   32'(V));
        check("bars_dones",  32'(dones),  32'd1);
        check("bars_data",   32'(derr),   32'd0);
        check("bars_x0",     32'(cap[0]), 32'h0000);
        check("bars_x79",    32'(cap[1]), 32'h0000);
        check("bars_x80",    32'(cap[2]), 32'h00FF);
        check("bars_x160",   32'(cap[3]), 32'hFF00);
        check("bars_x240",   32'(cap[4]), 32'hFFFF);
        after_done("bars", 16'd1);

        // solid with a 10-cycle FIFO stall at (63,0)
        do_start(2'd0, 16'hA55A);
        run(10, -1, -1);
        check("stall_no_write_full", 32'(full_wr),    32'd0);
        check("stall_resume_x",      32'(resume_idx), 32'd63);
        check("stall_resume_data",   32'(resume_data), 32'hA55A);
        check("stall_writes",        32'(writes),     32'(FRAME));
        check("stall_data",          32'(derr),       32'd0);
        check("stall_dones",         32'(dones),      32'd1);
        after_done("stall", 16'd2);

        // ramp, with a stray iSTART and mode change mid-frame
        do_start(2'd2, 16'h0000);
        run(0, 3, -1);
        check("ramp_x4_y2",   32'(cap[5]), 32'h0101);
        check("ramp_x255_y33", 32'(cap[6]), 32'h3F10);
        check("ramp_writes",  32'(writes), 32'(FRAME));
        check("ramp_data",    32'(derr),   32'd0);
        check("ramp_dones",   32'(dones),  32'd1);
        after_done("ramp", 16'd3);
        repeat (3) @(posedge clk);
        #2 check("ramp_no_restart", 32'(busy), 32'd0);

        // abort mid-frame at y=10, reset wins over a coincident iSTART
        do_start(2'd1, 16'h0000);
        run(0, -1, 10);
        check("abort_reached", 32'(aborted), 32'd1);
        check("abort_writes",  32'(writes),  32'(10 * H));
        check("abort_dones",   32'(dones),   32'd0);
        rst = 1'b1; start = 1'b1; mode = 2'd1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        #1;
        check("abort_wr_en", 32'(wr_en), 32'd0);
        check("abort_busy",  32'(busy),  32'd0);
        check("abort_done",  32'(done),  32'd0);
        check("abort_cnt",   32'(fcnt),  32'd0);
        check("abort_data",  32'(wdata), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        check("abort_start_ignored", 32'(busy), 32'd0);

        // checker, two back-to-back frames after the abort
        do_start(2'd3, 16'h0000);
        run(0, -1, -1);
        check("chk1_x0_y0",   32'(cap[0]), 32'h0000);
        check("chk1_x32_y0",  32'(cap[7]), 32'hFFFF);
        check("chk1_x32_y32", 32'(cap[8]), 32'h0000);
        check("chk1_writes",  32'(writes), 32'(FRAME));
        check("chk1_data",    32'(derr),   32'd0);
        check("chk1_dones",   32'(dones),  32'd1);
        after_done("chk1", 16'd1);
        do_start(2'd3, 16'h0000);
        run(0, -1, -1);
        check("chk2_x32_y0", 32'(cap[7]), 32'hFFFF);
        check("chk2_writes", 32'(writes), 32'(FRAME));
        check("chk2_data",   32'(derr),   32'd0);
        check("chk2_dones",  32'(dones),  32'd1);
        after_done("chk2", 16'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sdram_frame_writer.md
SDRAM_FRAME_WRITER -- requirements
Module: sdram_frame_writer

Interface
REQ-001 SHALL have parameter H_PIXELS, default 640, pixels per line.
REQ-002 SHALL have parameter V_LINES, default 480, lines per frame.
REQ-003 SHALL have one clock and a synchronous active-high reset, ports iCLK and iRST; port list in REQ-004..REQ-013.
REQ-004 iCLK  in  1  write-side clock (the SDRAM write FIFO clock).
REQ-005 iRST  in  1  synchronous active-high reset.
REQ-006 iSTART  in  1  single-cycle pulse requesting one full frame write.
REQ-007 iMODE  in  2  pattern select, latched at accepted iSTART.
REQ-008 iSOLID  in  16  solid colour value, latched at accepted iSTART.
REQ-009 iFIFO_FULL  in  1  write FIFO full flag, same clock domain.
REQ-010 oWR_DATA  out  16  pixel word, [15:8] red, [7:0] blue.
REQ-011 oWR_EN  out  1  FIFO write strobe; oWR_DATA valid when high.
REQ-012 oBUSY  out  1  frame write in progress.
REQ-013 oDONE  out  1  single-cycle pulse after last pixel written; oFRAME_CNT  out  16  completed frames, wraps 16'hFFFF->0.

Function
REQ-014 FSM states SHALL be IDLE, WRITE, LINE_END, DONE.
REQ-015 IDLE: iSTART=1 -> WRITE; latch iMODE and iSOLID; clear x, y to 0; oBUSY=1 from the next cycle.
REQ-016 iSTART SHALL be ignored in WRITE, LINE_END and DONE.
REQ-017 WRITE: oWR_EN SHALL be combinationally (state==WRITE && !iFIFO_FULL); each cycle with oWR_EN=1 writes one word and increments x.
REQ-018 iFIFO_FULL=1 SHALL stall: x, y, oWR_DATA held, no word lost or duplicated.
REQ-019 Write with x==H_PIXELS-1 -> LINE_END; x resets to 0.
REQ-020 LINE_END (exactly 1 cycle, oWR_EN=0): y==V_LINES-1 -> DONE, else y increments -> WRITE.
REQ-021 DONE (1 cycle): oDONE=1, oFRAME_CNT increments, oBUSY=0 from the next cycle -> IDLE.
REQ-022 A frame SHALL contain exactly H_PIXELS*V_LINES writes (307200 by default), row-major, x fastest.
REQ-023 oWR_DATA SHALL be a combinational function of latched mode/solid and current x, y.
REQ-024 Mode 0 (solid): oWR_DATA = latched iSOLID.
REQ-025 Mode 1 (colour bars): idx = x/80 (3 bits); red = idx[1]?8'hFF:8'h00, blue = idx[0]?8'hFF:8'h00.
REQ-026 Mode 2 (ramp): red = x[9:2], blue = y[8:1].
REQ-027 Mode 3 (checker): (x[5]^y[5]) ? 16'hFFFF : 16'h0000.
REQ-028 x SHALL be 10 bits and y 9 bits; no other arithmetic width extension.

Reset
REQ-029 iRST SHALL force state IDLE, x=0, y=0, oWR_EN=0, oBUSY=0, oDONE=0, oFRAME_CNT=0, latched mode=0, latched solid=0.
REQ-030 iRST mid-frame SHALL abort without oDONE and without incrementing oFRAME_CNT; iRST has priority over iSTART.

Structure
REQ-031 Mode encodings, FSM state encodings and the default geometry (640, 480, bar width 80) SHALL live in a shared package also used by the VGA read path.
REQ-032 Pattern generation SHALL be a separate combinational sub-module, frame_pattern_gen (inputs mode, solid, x, y; output 16-bit word).

Verification
REQ-033 Mode 1, iFIFO_FULL=0, iSTART: 307200 oWR_EN cycles, 480 one-cycle gaps; x=0..79 -> 16'h0000, x=80 -> 16'h00FF, x=160 -> 16'hFF00, x=240 -> 16'hFFFF; one oDONE; oFRAME_CNT=1.
REQ-034 Mode 0 iSOLID=16'hA55A, iFIFO_FULL held 1 for 10 cycles at x=63, y=0: no writes while full; next write is x=63, value 16'hA55A; total writes still 307200.
REQ-035 Mode 2: pixel (x=639, y=479) -> 16'h9FEF; pixel (4, 2) -> 16'h0101.
REQ-036 iSTART repeated during WRITE and iMODE changed: ignored; pattern unchanged; single oDONE.
REQ-037 iRST at y=100: outputs at reset values next cycle; no oDONE; new iSTART restarts at (0,0), writes 307200 words.
REQ-038 Mode 3, two back-to-back frames: (32,0) -> 16'hFFFF, (32,32) -> 16'h0000; oFRAME_CNT=2.
